tone_detector: RTL and testbench

Measures the frequency of an incoming square-wave tone and reports it as the same 10-bit frequency code the tone generator consumes, where code f corresponds to a full period of 1,000,000/f clk cycles. It sits on the audio input path, for example a loopback or a player's tone pad, and feeds the game controller's frequency-match logic. The measurement path is:

- synchronise the input;
- time successive rising edges;
- convert period to frequency with a sequential divider;
- publish the result only when consecutive measurements agree.

---
 rtl/tone_detector_if.sv | 27 ++
 rtl/tone_detector.sv | 175 +++++++++++++++++
 tb/tb_tone_detector.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tone_detector_if.sv
// Port bundle for tone_detector: the detector drives the result side (master),
// the audio front end / game controller sits on the other side (slave).
interface tone_detector_if;
    logic       sound_in;
    logic [9:0] frequency;
    logic       freq_valid;
    logic       tone_present;
    logic [1:0] state_dbg;

    // freq_valid is a one-cycle strobe with no ready/backpressure: frequency and
    // tone_present change on the same edge and the consumer samples them that cycle.
    modport master (
        input  sound_in,
        output frequency,
        output freq_valid,
        output tone_present,
        output state_dbg
    );

    modport slave (
        output sound_in,
        input  frequency,
        input  freq_valid,
        input  tone_present,
        input  state_dbg
    );
endinterface

// File: rtl/tone_detector.sv
// Square-wave tone detector: times rising edges, divides NUM by the period with a
// restoring divider and publishes the rounded frequency code once two readings agree.
module tone_detector #(
    parameter int NUM        = 1000000,
    parameter int MIN_PERIOD = 900,
    parameter int TIMEOUT    = 1048575,
    parameter int TOL        = 2
) (
    input logic             clk,
    input logic             rst,
    tone_detector_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, CHECK = 2'd2} state_t;

    localparam logic [19:0] CNT_MAX  = 20'hFFFFF;
    localparam logic [20:0] MIN_P    = 21'(MIN_PERIOD);
    localparam logic [19:0] TMO      = 20'(TIMEOUT);
    localparam logic [20:0] NUM_W    = 21'(NUM);
    localparam logic [10:0] TOL_W    = 11'(TOL);
    localparam logic [4:0]  LAST_BIT = 5'd20;

    logic        s1, s2, s3;
    logic        rise;
    logic [19:0] cnt;
    logic [20:0] cnt_p1;
    logic        accept;
    logic        armed;
    logic        timeout_hit;
    logic        start_meas;

    state_t      state, nxt;
    logic [20:0] divd;
    logic [19:0] rem;
    logic [19:0] divisor;
    logic [4:0]  bit_cnt;
    logic [20:0] trial;
    logic [20:0] trial_sub;
    logic        fits;
    logic [19:0] rem_n;

    logic [9:0]  qs;
    logic [9:0]  q_diff;
    logic [9:0]  prev_q;
    logic        have_prev;
    logic        discard;
    logic        commit;
    logic        publish;
    logic [9:0]  frequency;
    logic        freq_valid;
    logic        tone_present;

    // Front end: two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.sound_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise        = s2 & ~s3;
    assign cnt_p1      = {1'b0, cnt} + 21'd1;
    assign accept      = rise && (cnt_p1 >= MIN_P);
    assign timeout_hit = armed && (cnt == TMO);
    // A timeout in the same cycle as an edge unarms, so that edge starts nothing.
    assign start_meas  = accept && armed && !timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 20'd1;
            end
            if (timeout_hit) begin
                armed <= 1'b0;
            end else if (accept) begin
                armed <= 1'b1;
            end
        end
    end

    // Restoring division step. rem < divisor always holds, so a negative trial
    // difference shows up as bit 20 of the 21-bit subtraction.
    assign trial     = {rem, divd[20]};
    assign trial_sub = trial - {1'b0, divisor};
    assign fits      = ~trial_sub[20];
    assign rem_n     = fits ? trial_sub[19:0] : trial[19:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start_meas) nxt = DIV;
            DIV:     if (bit_cnt == LAST_BIT) nxt = CHECK;
            CHECK:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divd    <= '0;
            rem     <= '0;
            divisor <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE && start_meas) begin
            divd    <= NUM_W + {1'b0, cnt_p1[20:1]};
            divisor <= cnt_p1[19:0];
            rem     <= '0;
            bit_cnt <= '0;
        end else if (state == DIV) begin
            divd    <= {divd[19:0], fits};
            rem     <= rem_n;
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    assign qs      = (|divd[20:10]) ? 10'h3FF : divd[9:0];
    assign q_diff  = (qs >= prev_q) ? (qs - prev_q) : (prev_q - qs);
    assign commit  = (state == CHECK) && !discard && !timeout_hit;
    assign publish = commit && have_prev && ({1'b0, q_diff} <= TOL_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frequency    <= '0;
            freq_valid   <= 1'b0;
            tone_present <= 1'b0;
            prev_q       <= '0;
            have_prev    <= 1'b0;
            discard      <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (timeout_hit) begin
                frequency    <= '0;
                tone_present <= 1'b0;
                freq_valid   <= 1'b1;
                have_prev    <= 1'b0;
            end else if (commit) begin
                prev_q    <= qs;
                have_prev <= 1'b1;
                if (publish) begin
                    frequency    <= qs;
                    freq_valid   <= 1'b1;
                    tone_present <= 1'b1;
                end
            end
            // A division in flight when the tone is lost must not revive the lock.
            if (timeout_hit && state == DIV) begin
                discard <= 1'b1;
            end else if (state == CHECK) begin
                discard <= 1'b0;
            end
        end
    end

    assign bus.frequency    = frequency;
    assign bus.freq_valid   = freq_valid;
    assign bus.tone_present = tone_present;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector: an edge-level model queues expected pulses
// (code, tone_present, cycle); a negedge monitor pops and compares each freq_valid.
module tb_tone_detector;
    localparam int NUM        = 1000000;
    localparam int MIN_PERIOD = 900;
    localparam int TIMEOUT    = 6000;
    localparam int TOL        = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    // {due_cycle[31:0], tone_present, frequency[9:0]}
    logic [42:0] exp_q[$];

    int m_armed;
    int m_have_prev;
    int m_prev;
    int last_acc;

    tone_detector_if bus ();

    tone_detector #(
        .NUM        (NUM),
        .MIN_PERIOD (MIN_PERIOD),
        .TIMEOUT    (TIMEOUT),
        .TOL        (TOL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endfunction

    function automatic void push_exp(input int f, input int tp, input int due);
        logic [31:0] d;
        logic [9:0]  fv;
        logic        tv;
        d  = due;
        fv = f[9:0];
        tv = tp[0];
        exp_q.push_back({d, tv, fv});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge-level reference: a rising edge driven at cycle j is sampled at j+1,
    // so a publish lands after edge j+25.
    task automatic rise_model();
        int j;
        int gap;
        int q;
        int d;
        j   = cyc;
        gap = j - last_acc;
        if (gap >= MIN_PERIOD) begin
            last_acc = j;
            if (m_armed == 0) begin
                m_armed = 1;
            end else begin
                q = (NUM + gap / 2) / gap;
                if (q > 1023) q = 1023;
                d = (q >= m_prev) ? q - m_prev : m_prev - q;
                if (m_have_prev != 0 && d <= TOL) push_exp(q, 1, j + 25);
                m_prev      = q;
                m_have_prev = 1;
            end
        end
    endtask

    // Driver: n periods of p cycles (high first); glitch_at > 0 puts a 10-cycle
    // low dip at that offset into the third period.
    task automatic tone(input int p, input int n, input int glitch_at);
        logic lvl;
        for (int i = 0; i < n; i++) begin
            for (int t = 0; t < p; t++) begin
                lvl = (t < p / 2);
                if (glitch_at > 0 && i == 2 && t >= glitch_at && t < glitch_at + 10) lvl = 1'b0;
                if (lvl && !bus.sound_in) rise_model();
                bus.sound_in = lvl;
                tick();
            end
        end
    endtask

    task automatic silence(input int n);
        if (m_armed != 0 && (cyc - last_acc + n) > TIMEOUT + 4) begin
            push_exp(0, 0, last_acc + 4 + TIMEOUT);
            m_armed     = 0;
            m_have_prev = 0;
        end
        bus.sound_in = 1'b0;
        repeat (n) tick();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.freq_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pulse: freq_valid=1 frequency=%0d at cycle %0d, required no pulse",
                         bus.frequency, cyc);
            end else begin
                logic [42:0] e;
                e = exp_q.pop_front();
                check("pulse_frequency", int'(bus.frequency), int'(e[9:0]));
                check("pulse_tone_present", int'(bus.tone_present), int'(e[10]));
                check("pulse_cycle", cyc, int'(e[42:11]));
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.sound_in = 1'b0;
        m_armed      = 0;
        m_have_prev  = 0;
        m_prev       = 0;
        last_acc     = -1000000;

        repeat (3) tick();
        check("reset_frequency", int'(bus.frequency), 0);
        check("reset_freq_valid", int'(bus.freq_valid), 0);
        check("reset_tone_present", int'(bus.tone_present), 0);
        rst = 1'b0;
        tick();
        check("post_reset_freq_valid", int'(bus.freq_valid), 0);

        silence(1200);

        // 440-code tone, alternating 2272/2273-cycle periods
        for (int i = 0; i < 6; i++) tone((i % 2 == 1) ? 2273 : 2272, 1, 0);
        check("locked_440_frequency", int'(bus.frequency), 440);
        check("locked_440_tone_present", int'(bus.tone_present), 1);

        // Step 440 -> 500 -> 1000, then saturation at period 977
        tone(2000, 4, 0);
        tone(1000, 3, 0);
        check("locked_1000_frequency", int'(bus.frequency), 1000);
        tone(977, 3, 0);
        check("saturated_frequency", int'(bus.frequency), 1023);

        // Glitch while locked at 500
        tone(2000, 4, 300);
        check("after_glitch_frequency", int'(bus.frequency), 500);

        // Tone stops: single timeout pulse, then nothing
        silence(14000);
        check("timeout_frequency", int'(bus.frequency), 0);
        check("timeout_tone_present", int'(bus.tone_present), 0);

        // Restart needs three edges
        tone(2000, 3, 0);
        check("restart_frequency", int'(bus.frequency), 500);

        // Reset in the middle of a division
        bus.sound_in = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("mid_div_reset_frequency", int'(bus.frequency), 0);
        check("mid_div_reset_tone_present", int'(bus.tone_present), 0);
        check("mid_div_reset_freq_valid", int'(bus.freq_valid), 0);
        bus.sound_in = 1'b0;
        repeat (3) tick();
        rst         = 1'b0;
        m_armed     = 0;
        m_have_prev = 0;
        m_prev      = 0;
        last_acc    = cyc;
        check("mid_div_reset_state", int'(bus.state_dbg == 2'd0), 1);
        silence(1200);
        tone(2000, 3, 0);
        check("rearm_frequency", int'(bus.frequency), 500);
        silence(100);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
